sat_up_deinterleaver: RTL and testbench
=======================================

// Module: sat_up_deinterleaver
// PURPOSE
// - Receive-side counterpart of the SAT-uplink turbo interleaver.
// - Takes signed soft LLRs arriving in channel (interleaved) order and returns them in natural order.
// - Permutation is QPP: pi(j) = (f1*j + f2*j^2) mod K. The block writes sample j to address pi(j), then reads addresses 0..K-1.
// - Sits between the demapper and the turbo decoder input buffer. One block is in flight at a time.
// PARAMETERS
// - W     6     LLR width, signed two's complement
// - KMAX  6144  largest supported block length
// - AW    13    address width; must satisfy 2^AW >= KMAX
// PORTS
// - clk        in   1   clock; all state changes on the rising edge
// - n_rst      in   1   asynchronous active-low reset
// - sof        in   1   start of block; samples blk_len/f1/f2 when accepted
// - blk_len    in   AW  K, the block length
// - f1         in   AW  QPP coefficient f1, must be < K
// - f2         in   AW  QPP coefficient f2, must be < K
// - din        in   W   interleaved-order LLR
// - din_vld    in   1   din valid
// - din_rdy    out  1   din accepted when din_vld & din_rdy
// - dout       out  W   natural-order LLR
// - dout_vld   out  1   dout valid
// - dout_rdy   in   1   downstream ready
// - dout_last  out  1   set with dout_vld on sample K-1
// - busy       out  1   state != IDLE
// - err        out  1   one-cycle pulse: parameters rejected
// BEHAVIOUR
// - Reset values: din_rdy=0, dout=0, dout_vld=0, dout_last=0, busy=0, err=0. State=IDLE, all counters 0.
// - FSM IDLE -> WRITE -> READ -> IDLE.
// - IDLE, sof=1:
//   - If 2 <= blk_len <= KMAX and f1 < blk_len and f2 < blk_len: latch K, f1 and f2. Set pi=0, g=(f1+f2) mod K, d=(2*f2) mod K, j=0. Go to WRITE.
//   - Otherwise: pulse err and stay in IDLE.
// - WRITE:
//   - din_rdy=1.
//   - On each accepted beat: mem[pi] <= din; pi <= (pi+g) mod K; g <= (g+d) mod K; j <= j+1.
//   - Beat j=K-1 -> READ. din_rdy drops the cycle after that beat.
// - Mod rule: every operand is < K, so each mod is one compare and one conditional subtract at AW+1 bits. No multiplier, no divider.
// - READ:
//   - Read counter r runs 0..K-1. Memory is synchronous: data appears 1 cycle after the read is issued.
//   - Issue a read when (!dout_vld | dout_rdy) and r <= K-1. The cycle after issue: dout_vld=1 and dout=mem[r].
//   - While dout_vld & !dout_rdy, dout and dout_last hold stable (the memory read is gated off).
//   - First dout_vld appears 1 cycle after entering READ.
//   - When the beat with dout_last is accepted: dout_vld=0 and state -> IDLE on the same edge.
// - sof outside IDLE is ignored, with no err.
// - din_vld outside WRITE is ignored (din_rdy=0).
// - Throughput: 1 sample/clk on each side. Block latency is K+2 clk from the last write beat to the last output, with no backpressure.
// - n_rst asserted mid-block: abort immediately to the reset values. Memory contents are don't-care.
// - Memory is not cleared between blocks. Every address in 0..K-1 is written exactly once because pi is a bijection for valid QPP pairs. Validating the pair is the caller's job.
// STRUCTURE
// - Shared package/header:
//   - SATUP_LLR_W=6, SATUP_KMAX=6144, SATUP_AW=13
//   - state encodings ST_IDLE=2'd0, ST_WRITE=2'd1, ST_READ=2'd2
// - One sub-module, sat_up_llr_ram:
//   - simple dual-port memory, KMAX x W
//   - write port: wen/waddr/wdata
//   - read port: ren/raddr; rdata is registered and holds when ren=0
// - Top level: FSM, QPP address recursion, read counter, output handshake.
// TESTING
// - Permutation, K=40, f1=3, f2=10, din[j]=j, dout_rdy=1:
//   - dout[0]=0, dout[13]=1, dout[6]=2, dout[39]=pi^-1(39)
//   - exactly 40 beats; dout_last only on beat 39
// - Backpressure, same block, dout_rdy toggling 1,0,0,1 at random:
//   - dout holds stable while stalled
//   - order and values unchanged; no beat lost or duplicated
// - Rejection:
//   - sof with blk_len=1 -> err=1 for 1 clk, busy stays 0
//   - sof with f2=blk_len -> same response
// - Back-to-back blocks K=40 then K=6144 (f1=263, f2=480):
//   - each output matches the golden QPP model
//   - sof during the first block's WRITE phase is ignored
// - Reset abort:
//   - drop n_rst after 20 WRITE beats -> outputs at reset values immediately
//   - a following K=40 block is correct
// - Stall on input: din_vld gaps of 1-5 clk during WRITE -> result identical to the gap-free run.

Source files
------------

// File: rtl/sat_up_deinterleaver_pkg.sv
// Shared widths, FSM encoding and the modular-add helper for the SAT-uplink QPP deinterleaver.
package sat_up_deinterleaver_pkg;

  localparam int SATUP_LLR_W = 6;
  localparam int SATUP_KMAX  = 6144;
  localparam int SATUP_AW    = 13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  // Both operands are already < k, so one compare and one subtract is enough.
  function automatic logic [SATUP_AW-1:0] mod_add(input logic [SATUP_AW-1:0] a,
                                                  input logic [SATUP_AW-1:0] b,
                                                  input logic [SATUP_AW-1:0] k);
    logic [SATUP_AW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, k}) s = s - {1'b0, k};
    return s[SATUP_AW-1:0];
  endfunction

endpackage

// File: rtl/sat_up_deinterleaver_if.sv
// Block-setup, input stream and output stream signals of the deinterleaver.
interface sat_up_deinterleaver_if;
  import sat_up_deinterleaver_pkg::*;

  logic                   sof;
  logic [SATUP_AW-1:0]    blk_len;
  logic [SATUP_AW-1:0]    f1;
  logic [SATUP_AW-1:0]    f2;
  logic [SATUP_LLR_W-1:0] din;
  logic                   din_vld;
  logic                   din_rdy;
  logic [SATUP_LLR_W-1:0] dout;
  logic                   dout_vld;
  logic                   dout_rdy;
  logic                   dout_last;
  logic                   busy;
  logic                   err;

  modport slave (
    input  sof, blk_len, f1, f2, din, din_vld, dout_rdy,
    output din_rdy, dout, dout_vld, dout_last, busy, err
  );

  modport master (
    output sof, blk_len, f1, f2, din, din_vld, dout_rdy,
    input  din_rdy, dout, dout_vld, dout_last, busy, err
  );
endinterface

// File: rtl/sat_up_llr_ram.sv
// Simple dual-port LLR store: synchronous write, registered read that holds when ren is low.
module sat_up_llr_ram
  import sat_up_deinterleaver_pkg::*;
#(
  parameter int DEPTH = SATUP_KMAX,
  parameter int W     = SATUP_LLR_W,
  parameter int AW    = SATUP_AW
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          wen,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          ren,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (wen) r_mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)   r_rdata <= '0;
    else if (ren) r_rdata <= r_mem[raddr];
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/sat_up_deinterleaver.sv
// QPP deinterleaver: writes channel-order LLRs to pi(j), then streams addresses 0..K-1 out.
// state    | meaning
// ST_IDLE  | waiting for sof, parameter check
// ST_WRITE | accepting K input beats at recursive QPP addresses
// ST_READ  | streaming memory out in natural order
module sat_up_deinterleaver
  import sat_up_deinterleaver_pkg::*;
(
  input  logic                   clk,
  input  logic                   n_rst,
  sat_up_deinterleaver_if.slave  bus
);

  localparam logic [SATUP_AW-1:0] KMAX_L = SATUP_AW'(SATUP_KMAX);

  state_t              r_state, w_state_nxt;
  logic [SATUP_AW-1:0] r_k, r_pi, r_g, r_d, r_j, r_r;
  logic                r_dout_vld, r_dout_last, r_err;
  logic                w_params_ok, w_start, w_reject, w_din_rdy, w_wr_beat, w_ren;

  assign w_params_ok = (bus.blk_len >= SATUP_AW'(2)) && (bus.blk_len <= KMAX_L) &&
                       (bus.f1 < bus.blk_len) && (bus.f2 < bus.blk_len);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_din_rdy   = 1'b0;
    w_start     = 1'b0;
    w_reject    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.sof) begin
          if (w_params_ok) begin
            w_start     = 1'b1;
            w_state_nxt = ST_WRITE;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        w_din_rdy = 1'b1;
        if (bus.din_vld && (r_j == r_k - 1'b1)) w_state_nxt = ST_READ;
      end
      ST_READ: begin
        if (r_dout_vld && bus.dout_rdy && r_dout_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_wr_beat = w_din_rdy & bus.din_vld;
  // A new read only when the output register is empty or being drained, so a stall freezes dout.
  assign w_ren = (r_state == ST_READ) && (!r_dout_vld || bus.dout_rdy) && (r_r < r_k);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_k         <= '0;
      r_pi        <= '0;
      r_g         <= '0;
      r_d         <= '0;
      r_j         <= '0;
      r_r         <= '0;
      r_dout_vld  <= 1'b0;
      r_dout_last <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_reject;
      if (w_start) begin
        r_k  <= bus.blk_len;
        r_pi <= '0;
        r_g  <= mod_add(bus.f1, bus.f2, bus.blk_len);
        r_d  <= mod_add(bus.f2, bus.f2, bus.blk_len);
        r_j  <= '0;
        r_r  <= '0;
      end
      // pi(j+1) = pi(j) + g(j), g(j+1) = g(j) + 2*f2: second-difference form of the QPP.
      if (w_wr_beat) begin
        r_pi <= mod_add(r_pi, r_g, r_k);
        r_g  <= mod_add(r_g, r_d, r_k);
        r_j  <= r_j + 1'b1;
      end
      if (w_ren) begin
        r_r         <= r_r + 1'b1;
        r_dout_vld  <= 1'b1;
        r_dout_last <= (r_r == r_k - 1'b1);
      end else if (bus.dout_rdy) begin
        r_dout_vld  <= 1'b0;
        r_dout_last <= 1'b0;
      end
    end
  end

  sat_up_llr_ram u_ram (
    .clk   (clk),
    .n_rst (n_rst),
    .wen   (w_wr_beat),
    .waddr (r_pi),
    .wdata (bus.din),
    .ren   (w_ren),
    .raddr (r_r),
    .rdata (bus.dout)
  );

  assign bus.din_rdy   = w_din_rdy;
  assign bus.dout_vld  = r_dout_vld;
  assign bus.dout_last = r_dout_last;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.err       = r_err;

endmodule

// File: tb/tb_sat_up_deinterleaver.sv
// Scoreboard bench for sat_up_deinterleaver: expected natural-order beats are queued at block start.
module tb_sat_up_deinterleaver;
  import sat_up_deinterleaver_pkg::*;

  typedef struct packed {
    logic [5:0] d;
    logic       last;
  } beat_t;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  sat_up_deinterleaver_if ifc();
  sat_up_deinterleaver dut (.clk(clk), .n_rst(n_rst), .bus(ifc));

  beat_t      exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         mon_beats = 0;
  int         err_seen = 0;
  bit         bp_en = 1'b0;
  logic       stall_pend = 1'b0;
  logic [5:0] stall_d;
  logic       stall_l;
  logic [5:0] cap    [SATUP_KMAX];
  logic [5:0] ref40  [40];
  logic [5:0] dv_m   [SATUP_KMAX];
  logic [5:0] expo_m [SATUP_KMAX];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int qpp(input int k, input int f1, input int f2, input int j);
    longint v;
    v = (longint'(f1) * j + longint'(f2) * j * j) % k;
    return int'(v);
  endfunction

  function automatic logic [5:0] dval(input int k, input int j);
    int v;
    v = (k == 40) ? j : (j * 37 + (j >> 6));
    return v[5:0];
  endfunction

  // Monitor: pops and compares on every accepted output beat, and checks hold during stalls.
  always @(negedge clk) begin
    if (ifc.err) err_seen++;
    if (!n_rst) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        check("stall_hold_data", {26'd0, ifc.dout}, {26'd0, stall_d});
        check("stall_hold_last", {31'd0, ifc.dout_last}, {31'd0, stall_l});
      end
      stall_pend = ifc.dout_vld && !ifc.dout_rdy;
      stall_d    = ifc.dout;
      stall_l    = ifc.dout_last;
      if (ifc.dout_vld && ifc.dout_rdy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {26'd0, ifc.dout}, 32'hFFFF_FFFF);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check($sformatf("dout[%0d]", mon_beats), {26'd0, ifc.dout}, {26'd0, e.d});
          check($sformatf("last[%0d]", mon_beats), {31'd0, ifc.dout_last}, {31'd0, e.last});
        end
        if (mon_beats < SATUP_KMAX) cap[mon_beats] = ifc.dout;
        mon_beats++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      ifc.dout_rdy = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_din_rdy"},   {31'd0, ifc.din_rdy},   32'd0);
    check({tag, "_dout"},      {26'd0, ifc.dout},      32'd0);
    check({tag, "_dout_vld"},  {31'd0, ifc.dout_vld},  32'd0);
    check({tag, "_dout_last"}, {31'd0, ifc.dout_last}, 32'd0);
    check({tag, "_busy"},      {31'd0, ifc.busy},      32'd0);
    check({tag, "_err"},       {31'd0, ifc.err},       32'd0);
  endtask

  task automatic run_block(input int k, input int f1, input int f2,
                           input bit gaps, input bit mid_sof, input int abort_at);
    int e0, t;
    for (int j = 0; j < k; j++) begin
      dv_m[j] = dval(k, j);
      expo_m[qpp(k, f1, f2, j)] = dv_m[j];
    end
    for (int i = 0; i < k; i++) exp_q.push_back({expo_m[i], (i == k - 1)});
    mon_beats = 0;
    e0 = err_seen;
    @(posedge clk); #1;
    ifc.sof = 1'b1; ifc.blk_len = 13'(k); ifc.f1 = 13'(f1); ifc.f2 = 13'(f2);
    @(posedge clk); #1;
    ifc.sof = 1'b0;
    check("busy_after_sof", {31'd0, ifc.busy}, 32'd1);
    for (int j = 0; j < k; j++) begin
      ifc.din = dv_m[j];
      ifc.din_vld = 1'b1;
      if (mid_sof && j == 10) begin
        ifc.sof = 1'b1; ifc.blk_len = 13'd6144; ifc.f1 = 13'd263; ifc.f2 = 13'd480;
      end
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!ifc.din_rdy && t < 50);
      if (!ifc.din_rdy) begin
        check("din_rdy_timeout", 32'd0, 32'd1);
        ifc.din_vld = 1'b0;
        exp_q.delete();
        return;
      end
      @(posedge clk); #1;
      ifc.sof = 1'b0;
      if (abort_at == j + 1) begin
        n_rst = 1'b0;
        #1;
        check_reset_outputs("abort");
        exp_q.delete();
        ifc.din_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        return;
      end
      if (gaps && $urandom_range(0, 2) == 0) begin
        ifc.din_vld = 1'b0;
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1;
      end
    end
    ifc.din_vld = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (ifc.busy && t < k * 4 + 50);
    check("block_done", {31'd0, ifc.busy}, 32'd0);
    check("beat_count", 32'(mon_beats), 32'(k));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    if (mid_sof) check("mid_sof_no_err", 32'(err_seen - e0), 32'd0);
  endtask

  task automatic reject(input int k, input int f1, input int f2, input string tag);
    int e0, busy_hi;
    e0 = err_seen;
    busy_hi = 0;
    @(posedge clk); #1;
    ifc.sof = 1'b1; ifc.blk_len = 13'(k); ifc.f1 = 13'(f1); ifc.f2 = 13'(f2);
    @(posedge clk); #1;
    ifc.sof = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ifc.busy) busy_hi++;
    end
    check({tag, "_err_pulses"}, 32'(err_seen - e0), 32'd1);
    check({tag, "_busy"}, 32'(busy_hi), 32'd0);
  endtask

  task automatic cmp_ref(input string tag);
    int nmis;
    nmis = 0;
    for (int i = 0; i < 40; i++) if (cap[i] !== ref40[i]) nmis++;
    check(tag, 32'(nmis), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.sof = 1'b0; ifc.blk_len = '0; ifc.f1 = '0; ifc.f2 = '0;
    ifc.din = '0; ifc.din_vld = 1'b0; ifc.dout_rdy = 1'b1;
    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    n_rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset");

    run_block(40, 3, 10, 1'b0, 1'b0, -1);
    check("perm_dout0",  {26'd0, cap[0]},  32'd0);
    check("perm_dout13", {26'd0, cap[13]}, 32'd1);
    check("perm_dout6",  {26'd0, cap[6]},  32'd2);
    check("perm_dout39", {26'd0, cap[39]}, 32'd23);
    for (int i = 0; i < 40; i++) ref40[i] = cap[i];

    bp_en = 1'b1;
    run_block(40, 3, 10, 1'b0, 1'b0, -1);
    bp_en = 1'b0;
    cmp_ref("backpressure_vs_ref");

    reject(1, 0, 0, "rej_len1");
    reject(40, 3, 40, "rej_f2eqk");

    run_block(40, 3, 10, 1'b0, 1'b1, -1);
    cmp_ref("b2b_first_vs_ref");
    run_block(6144, 263, 480, 1'b0, 1'b0, -1);

    run_block(40, 3, 10, 1'b0, 1'b0, 20);
    run_block(40, 3, 10, 1'b0, 1'b0, -1);
    cmp_ref("after_abort_vs_ref");

    run_block(40, 3, 10, 1'b1, 1'b0, -1);
    cmp_ref("gaps_vs_ref");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
